// File: rtl/sat_counter.sv
// sat_counter: up/down counter saturating at [lim_lo, lim_hi]; SAT_COUNTER_STICKY_EN adds a sticky saturation flag.
module sat_counter #(
  parameter int WIDTH   = 8,
  parameter int STEP_W  = 4,
  parameter int RST_VAL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  lim_lo,
  input  logic [WIDTH-1:0]  lim_hi,
  output logic [WIDTH-1:0]  count,
  output logic              at_max,
  output logic              at_min,
  output logic              sat_hit,
  output logic              cfg_err
`ifdef SAT_COUNTER_STICKY_EN
  ,
  input  logic              sticky_clr,
  output logic              sat_sticky
`endif
);
  logic [WIDTH-1:0]         r_count;
  logic                     r_hit;
  logic signed [WIDTH+1:0]  w_ideal;
  logic signed [WIDTH+1:0]  w_lo_s;
  logic signed [WIDTH+1:0]  w_hi_s;
  logic signed [WIDTH+1:0]  w_step_s;
  logic                     w_en_lo;
  logic                     w_en_hi;
  logic [WIDTH-1:0]         w_en_val;
  logic [WIDTH-1:0]         w_ld_val;
  logic                     w_ld_clip;
  logic [WIDTH-1:0]         w_next;
  logic                     w_hit;
  assign w_lo_s   = $signed({2'b00, lim_lo});
  assign w_hi_s   = $signed({2'b00, lim_hi});
  assign w_step_s = $signed({{(WIDTH+2-STEP_W){1'b0}}, step});
  // Two guard bits keep both the up overflow and the down underflow representable.
  assign w_ideal  = mode ? $signed({2'b00, r_count}) + w_step_s : $signed({2'b00, r_count}) - w_step_s;
  assign w_en_lo  = w_ideal < w_lo_s;
  assign w_en_hi  = w_ideal > w_hi_s;
  assign w_en_val = w_en_lo ? lim_lo : w_en_hi ? lim_hi : w_ideal[WIDTH-1:0];
  assign w_ld_val = load_val < lim_lo ? lim_lo : load_val > lim_hi ? lim_hi : load_val;
  assign w_ld_clip = (load_val < lim_lo) || (load_val > lim_hi);
  assign cfg_err  = lim_lo > lim_hi;
  always_comb begin
    w_next = r_count;
    w_hit  = 1'b0;
    if (!cfg_err && load) begin
      w_next = w_ld_val;
      w_hit  = w_ld_clip;
    end else if (!cfg_err && en) begin
      w_next = w_en_val;
      w_hit  = w_en_lo || w_en_hi;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= WIDTH'(RST_VAL);
      r_hit   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_hit   <= w_hit;
    end
  end
`ifdef SAT_COUNTER_STICKY_EN
  logic r_sticky;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sticky <= 1'b0;
    else        r_sticky <= w_hit ? 1'b1 : sticky_clr ? 1'b0 : r_sticky;
  end
  assign sat_sticky = r_sticky;
`endif
  assign count   = r_count;
  assign sat_hit = r_hit;
  assign at_max  = r_count == lim_hi;
  assign at_min  = r_count == lim_lo;
endmodule

// File: tb/tb_sat_counter.sv
// tb_sat_counter: scoreboard bench for sat_counter against an integer reference model.
module tb_sat_counter;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       en = 0, mode = 0, load = 0;
  logic [3:0] step = 0;
  logic [7:0] load_val = 0, lim_lo = 0, lim_hi = 8'hFF;
  logic [7:0] count;
  logic       at_max, at_min, sat_hit, cfg_err;
  logic       sticky_clr = 0;
  logic       sat_sticky;
  int checks = 0, errors = 0;
  typedef struct {int cnt; bit hit; int lo; int hi; bit stk;} exp_t;
  exp_t q[$];
  int m_cnt = 0;
  bit m_stk = 0;

  sat_counter #(.WIDTH(8), .STEP_W(4), .RST_VAL(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .step(step), .load(load),
    .load_val(load_val), .lim_lo(lim_lo), .lim_hi(lim_hi), .count(count),
    .at_max(at_max), .at_min(at_min), .sat_hit(sat_hit), .cfg_err(cfg_err)
`ifdef SAT_COUNTER_STICKY_EN
    , .sticky_clr(sticky_clr), .sat_sticky(sat_sticky)
`endif
  );
`ifndef SAT_COUNTER_STICKY_EN
  assign sat_sticky = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction

  task automatic cyc(input bit e, input bit md, input int st, input bit ld, input int lv,
                     input int lo, input int hi, input bit clr);
    exp_t x;
    int ideal, nc;
    bit h;
    @(negedge clk);
    en = e; mode = md; step = 4'(st); load = ld; load_val = 8'(lv);
    lim_lo = 8'(lo); lim_hi = 8'(hi); sticky_clr = clr;
    if (lo > hi) begin
      nc = m_cnt; h = 0;
    end else if (ld) begin
      nc = clamp(lv, lo, hi); h = nc != lv;
    end else if (e) begin
      ideal = md ? m_cnt + st : m_cnt - st;
      nc = clamp(ideal, lo, hi); h = nc != ideal;
    end else begin
      nc = m_cnt; h = 0;
    end
    m_stk = h ? 1 : clr ? 0 : m_stk;
    m_cnt = nc;
    x.cnt = nc; x.hit = h; x.lo = lo; x.hi = hi; x.stk = m_stk;
    q.push_back(x);
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("count", int'(count), x.cnt);
      chk("sat_hit", int'(sat_hit), int'(x.hit));
      chk("at_max", int'(at_max), int'(x.cnt == x.hi));
      chk("at_min", int'(at_min), int'(x.cnt == x.lo));
      chk("cfg_err", int'(cfg_err), int'(x.lo > x.hi));
`ifdef SAT_COUNTER_STICKY_EN
      chk("sat_sticky", int'(sat_sticky), int'(x.stk));
`endif
    end
  end

  initial begin
    int lo, hi, t;
    #12;
    chk("reset_count", int'(count), 0);
    chk("reset_hit", int'(sat_hit), 0);
    @(negedge clk);
    rst_n = 1;
    // Count up to 0x37 then reset asynchronously mid-cycle with load/en active.
    cyc(0, 0, 0, 1, 'h30, 0, 'hFF, 0);
    cyc(1, 1, 7, 0, 0, 0, 'hFF, 0);
    @(posedge clk); #3;
    chk("pre_reset_count", int'(count), 'h37);
    en = 1; mode = 1; step = 4'd5; load = 1; load_val = 8'hAA;
    rst_n = 0;
    #1;
    chk("async_reset_count", int'(count), 0);
    chk("async_reset_hit", int'(sat_hit), 0);
    @(posedge clk); #1;
    chk("reset_override_count", int'(count), 0);
    m_cnt = 0; m_stk = 0;
    @(negedge clk);
    rst_n = 1; en = 0; load = 0;
    // Up saturation at lim_hi, then a further enable at the limit.
    cyc(0, 0, 0, 1, 'hEE, 'h10, 'hF0, 0);
    cyc(1, 1, 5, 0, 0, 'h10, 'hF0, 0);
    cyc(1, 1, 5, 0, 0, 'h10, 'hF0, 0);
    // Down saturation at lim_lo, then step 0 holds without a clip; sticky clear racing a clip.
    cyc(0, 0, 0, 1, 'h12, 'h10, 'hF0, 0);
    cyc(1, 0, 3, 0, 0, 'h10, 'hF0, 1);
    cyc(1, 0, 0, 0, 0, 'h10, 'hF0, 0);
    cyc(0, 0, 0, 0, 0, 'h10, 'hF0, 1);
    // Load beats enable and is clamped.
    cyc(1, 1, 3, 1, 'hFF, 'h20, 'h80, 0);
    cyc(1, 0, 3, 1, 'h05, 'h20, 'h80, 0);
    // Inverted limits freeze the counter.
    cyc(1, 1, 9, 1, 'h33, 'h90, 'h40, 0);
    cyc(1, 0, 9, 0, 0, 'h90, 'h40, 0);
    // Count left outside a narrowed window is pulled back in, even with step 0.
    cyc(0, 0, 0, 1, 'h50, 0, 'hFF, 0);
    cyc(1, 1, 0, 0, 0, 'h60, 'h70, 0);
    cyc(0, 0, 0, 1, 'hFF, 0, 'hFF, 0);
    cyc(1, 1, 15, 0, 0, 0, 'hFF, 0);
    cyc(0, 0, 0, 1, 'h02, 0, 'hFF, 0);
    cyc(1, 0, 15, 0, 0, 0, 'hFF, 0);
    for (int i = 0; i < 400; i++) begin
      lo = $urandom_range(0, 120);
      hi = $urandom_range(100, 255);
      if ($urandom_range(0, 9) == 0) begin
        t = lo; lo = hi; hi = t;
      end
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 15),
          $urandom_range(0, 9) < 2, $urandom_range(0, 255), lo, hi, $urandom_range(0, 3) == 0);
    end
    repeat (4) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sat_counter.md
SAT_COUNTER -- requirements
Module: sat_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter and limit width in bits; SHALL be >= 2.
REQ-002 Parameter STEP_W, default 4: width of the step input; SHALL be <= WIDTH.
REQ-003 Parameter RST_VAL, default 0: count value loaded on reset.
REQ-004 Port clk  in  1: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  in  1: asynchronous, active-low reset.
REQ-006 Port en  in  1: count enable.
REQ-007 Port mode  in  1: count direction; 1 = up, 0 = down.
REQ-008 Port step  in  STEP_W: unsigned increment/decrement magnitude.
REQ-009 Port load  in  1: synchronous load request.
REQ-010 Port load_val  in  WIDTH: value to load.
REQ-011 Port lim_lo  in  WIDTH: unsigned lower saturation limit.
REQ-012 Port lim_hi  in  WIDTH: unsigned upper saturation limit.
REQ-013 Port count  out  WIDTH: registered counter value.
REQ-014 Port at_max  out  1: combinational; asserted when count == lim_hi.
REQ-015 Port at_min  out  1: combinational; asserted when count == lim_lo.
REQ-016 Port sat_hit  out  1: registered one-cycle pulse; asserted for the cycle after any update was clipped.
REQ-017 Port cfg_err  out  1: combinational; asserted when lim_lo > lim_hi.

Function
REQ-018 Update priority SHALL be: cfg_err (hold) > load > en (count) > hold.
REQ-019 When cfg_err = 1, count SHALL hold; load and en SHALL be ignored; sat_hit SHALL be 0 next cycle.
REQ-020 On load, count SHALL become load_val clamped to [lim_lo, lim_hi]; sat_hit SHALL pulse if clamping occurred.
REQ-021 On en with mode = 1, the ideal result SHALL be count + step, computed in WIDTH+1 bits; a result > lim_hi SHALL give lim_hi.
REQ-022 On en with mode = 0, the ideal result SHALL be count - step, computed signed in WIDTH+1 bits; a result < lim_lo SHALL give lim_lo.
REQ-023 Every enabled result SHALL also be clamped to [lim_lo, lim_hi], including when count was already outside the window after a limit change.
REQ-024 sat_hit SHALL pulse whenever the ideal result differs from the stored result, including en at a limit with step > 0.
REQ-025 With step = 0 and en = 1, count SHALL hold and sat_hit SHALL be 0, unless count is outside the window, in which case REQ-023 applies.
REQ-026 Latency: count and sat_hit SHALL reflect inputs sampled at edge N on edge N; at_max, at_min and cfg_err SHALL follow count and the limits combinationally.
REQ-027 The counter SHALL never wrap around modulo 2^WIDTH.

Reset
REQ-028 While rst_n = 0, count SHALL immediately be RST_VAL and sat_hit SHALL be 0, regardless of clk.
REQ-029 Reset deassertion SHALL take effect synchronously; the first update SHALL occur on the first rising clk edge with rst_n = 1.
REQ-030 Assertion of rst_n mid-operation SHALL override load and en in the same cycle.

Configuration
REQ-031 Macro SAT_COUNTER_STICKY_EN, when defined, SHALL add input sticky_clr (1 bit) and output sat_sticky (1 bit, registered, reset 0).
REQ-032 With SAT_COUNTER_STICKY_EN defined, sat_sticky SHALL set on any cycle that produces sat_hit and clear on sticky_clr; if both occur in the same cycle, set SHALL win.
REQ-033 Without SAT_COUNTER_STICKY_EN, the sticky_clr and sat_sticky ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8, STEP_W=4, RST_VAL=0)
REQ-034 Apply rst_n=0 mid-count at count=0x37 -> count=0x00 immediately; sat_hit=0.
REQ-035 Set lo=0x10, hi=0xF0, count=0xEE; en=1, mode=1, step=5 -> count=0xF0, sat_hit=1; next cycle -> count stays 0xF0, sat_hit=1, at_max=1.
REQ-036 Set lo=0x10, count=0x12; en=1, mode=0, step=3 -> count=0x10, sat_hit=1, at_min=1; then step=0 -> hold, sat_hit=0.
REQ-037 Set lo=0x20, hi=0x80; load=1 with load_val=0xFF and en=1 -> count=0x80, sat_hit=1 (load wins over en).
REQ-038 Set lo=0x90, hi=0x40 -> cfg_err=1; load and en have no effect; count unchanged.
REQ-039 With SAT_COUNTER_STICKY_EN: saturate once -> sat_sticky=1 and held; then sticky_clr=1 in the same cycle as a new clip -> sat_sticky stays 1; sticky_clr=1 without a clip -> sat_sticky=0.
